dtpu_infifo: RTL and testbench

- Input-side FIFO that feeds the accelerator's acc_fifo_read interface (RD_DATA / RD_EN / EMPTY_N).
- Accepts activation words from the DMA over an AXI4-Stream slave port and buffers them.
- Presents the words first-word-fall-through to the core's infifo_dout / infifo_read / infifo_is_empty pins.
- Sits in the block design between the AXI DMA MM2S stream and dtpu_core.

---
 rtl/dtpu_infifo_pkg.sv | 17 +
 rtl/dtpu_fifo_mem.sv | 26 ++
 rtl/dtpu_infifo.sv | 93 +++++++++
 tb/tb_dtpu_infifo.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dtpu_infifo_pkg.sv
// Shared infifo constants and the pointer-width helper.
// The core and the input FIFO both import this package.
package dtpu_infifo_pkg;

    localparam int unsigned INFIFO_DATA_WIDTH = 64;
    localparam int unsigned INFIFO_DEPTH      = 16;
    localparam int unsigned INFIFO_AFULL_THR  = 12;

    // Ceiling log2. The result is the pointer width for a power-of-two depth.
    function automatic int unsigned clog2_int(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) r++;
        return r;
    endfunction

endpackage

// File: rtl/dtpu_fifo_mem.sv
// Simple dual-port storage for the input FIFO.
// The write port is synchronous and the read port is asynchronous; the array itself is not reset.
module dtpu_fifo_mem
    import dtpu_infifo_pkg::*;
#(
    parameter int unsigned WIDTH = INFIFO_DATA_WIDTH + 1,
    parameter int unsigned DEPTH = INFIFO_DEPTH,
    parameter int unsigned AW    = clog2_int(INFIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/dtpu_infifo.sv
// First-word-fall-through input FIFO between the AXI DMA MM2S stream and dtpu_core.
// Pointer, count and sticky-flag logic live here; the storage is in dtpu_fifo_mem.
module dtpu_infifo
    import dtpu_infifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = INFIFO_DATA_WIDTH,
    parameter int unsigned DEPTH      = INFIFO_DEPTH,
    parameter int unsigned AFULL_THR  = INFIFO_AFULL_THR
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic                          s_axis_tvalid,
    input  logic                          s_axis_tlast,
    output logic                          s_axis_tready,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          rd_last,
    input  logic                          rd_en,
    output logic                          empty_n,
    output logic [clog2_int(DEPTH):0]     level,
    output logic                          almost_full,
    output logic                          overflow_err,
    output logic                          underflow_err
);

    localparam int unsigned AW = clog2_int(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_THR);

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  do_wr;
    logic                  do_pop;
    logic [DATA_WIDTH:0]   mem_q;

    // Flow control comes from the registered count only, so a same-cycle pop
    // never opens tready on a full FIFO.
    assign s_axis_tready = ~reset & ~flush & (count != FULL_CNT);
    assign empty_n       = (count != '0);
    assign level         = count;
    assign almost_full   = (count >= AFULL_CNT);

    assign do_wr  = s_axis_tvalid & s_axis_tready;
    assign do_pop = rd_en & empty_n & ~flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (rd_en & ~empty_n) underflow_err <= 1'b1;
            // tready already excludes the full case, so this never fires in practice.
            if (s_axis_tvalid & s_axis_tready & (count == FULL_CNT)) overflow_err <= 1'b1;

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_wr)  wr_ptr <= wr_ptr + AW'(1);
                if (do_pop) rd_ptr <= rd_ptr + AW'(1);
                case ({do_wr, do_pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    dtpu_fifo_mem #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (do_wr),
        .wr_addr (wr_ptr),
        .wr_data ({s_axis_tlast, s_axis_tdata}),
        .rd_addr (rd_ptr),
        .rd_data (mem_q)
    );

    assign rd_data = empty_n ? mem_q[DATA_WIDTH-1:0] : '0;
    assign rd_last = empty_n & mem_q[DATA_WIDTH];

endmodule

// File: tb/tb_dtpu_infifo.sv
// Self-checking bench for dtpu_infifo: a queue-based model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_dtpu_infifo;

    localparam int DW    = 64;
    localparam int DEPTH = 16;
    localparam int AFT   = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          rd_en = 1'b0;
    logic          empty_n;
    logic [4:0]    level;
    logic          almost_full;
    logic          overflow_err;
    logic          underflow_err;

    dtpu_infifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THR(AFT)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .rd_data       (rd_data),
        .rd_last       (rd_last),
        .rd_en         (rd_en),
        .empty_n       (empty_n),
        .level         (level),
        .almost_full   (almost_full),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of stored words plus the sticky underflow flag.
    typedef struct packed { logic l; logic [DW-1:0] d; } ent_t;
    ent_t q[$];
    bit   m_uf = 1'b0;
    bit   mon_en = 1'b0;

    always @(posedge clk) begin
        int n;
        n = q.size();
        if (reset) begin
            q.delete();
            m_uf = 1'b0;
        end else begin
            if (rd_en && n == 0) m_uf = 1'b1;
            if (flush) q.delete();
            else begin
                if (rd_en && n != 0) void'(q.pop_front());
                if (s_axis_tvalid && n != DEPTH) q.push_back('{l: s_axis_tlast, d: s_axis_tdata});
            end
        end
    end

    always @(negedge clk) begin
        int n;
        n = q.size();
        if (mon_en) begin
            chk("tready",      64'(s_axis_tready), 64'(!reset && !flush && n != DEPTH));
            chk("empty_n",     64'(empty_n),       64'(n != 0));
            chk("level",       64'(level),         64'(n));
            chk("almost_full", 64'(almost_full),   64'(n >= AFT));
            chk("rd_data",     rd_data,            (n != 0) ? q[0].d : 64'd0);
            chk("rd_last",     64'(rd_last),       64'((n != 0) ? q[0].l : 1'b0));
            chk("underflow",   64'(underflow_err), 64'(m_uf));
            chk("overflow",    64'(overflow_err),  64'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int idx_w, idx_r, cyc, n;

        // Reset then idle
        @(posedge clk);
        #1 mon_en = 1'b1;
        step();
        step();
        #1;
        chk("rst_level",  64'(level), 64'd0);
        chk("rst_tready", 64'(s_axis_tready), 64'd0);
        chk("rst_rdata",  rd_data, 64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_tready", 64'(s_axis_tready), 64'd1);
        chk("post_rst_empty",  64'(empty_n), 64'd0);

        // Single word
        step();
        s_axis_tdata = 64'h0123_4567_89AB_CDEF; s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
        step();
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        #1;
        chk("single_data",  rd_data, 64'h0123456789ABCDEF);
        chk("single_last",  64'(rd_last), 64'd1);
        chk("single_level", 64'(level), 64'd1);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        #1;
        chk("single_pop_empty", 64'(empty_n), 64'd0);
        chk("single_pop_data",  rd_data, 64'd0);

        // Fill to full
        step();
        for (int i = 0; i < DEPTH; i++) begin
            s_axis_tdata = 64'(i); s_axis_tvalid = 1'b1;
            step();
            #1;
            chk("fill_afull", 64'(almost_full), 64'(i + 1 >= AFT));
        end
        s_axis_tdata = 64'hDEAD;
        #1;
        chk("full_tready", 64'(s_axis_tready), 64'd0);
        step();
        #1;
        chk("full_level", 64'(level), 64'd16);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        #1;
        chk("after_pop_tready", 64'(s_axis_tready), 64'd1);
        step();
        s_axis_tvalid = 1'b0;
        #1;
        chk("dead_accepted_level", 64'(level), 64'd16);
        for (int k = 0; k < DEPTH; k++) begin
            rd_en = 1'b1;
            #1;
            chk("drain_order", rd_data, (k < 15) ? 64'(k + 1) : 64'hDEAD);
            step();
        end
        rd_en = 1'b0;

        // Wrap-around with concurrent random traffic
        idx_w = 0; idx_r = 0; cyc = 0;
        while (idx_r < 40 && cyc < 3000) begin
            n = q.size();
            s_axis_tvalid = (idx_w < 40) && (n < 15) && ($urandom_range(0, 3) != 0);
            s_axis_tdata  = 64'(idx_w);
            s_axis_tlast  = (idx_w % 8 == 7);
            rd_en = ((n > 1) || (idx_w == 40 && n > 0)) && ($urandom_range(0, 1) == 1);
            #1;
            if (rd_en) begin
                chk("wrap_order", rd_data, 64'(idx_r));
                idx_r++;
            end
            if (s_axis_tvalid) idx_w++;
            step();
            cyc++;
        end
        s_axis_tvalid = 1'b0; rd_en = 1'b0;
        chk("wrap_completed", 64'(idx_r), 64'd40);

        // Underflow
        step();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        #1;
        chk("uf_set",   64'(underflow_err), 64'd1);
        chk("uf_level", 64'(level), 64'd0);
        s_axis_tdata = 64'h55; s_axis_tvalid = 1'b1;
        step();
        s_axis_tvalid = 1'b0;
        #1;
        chk("uf_ptr_data", rd_data, 64'h55);
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        chk("uf_after_flush", 64'(underflow_err), 64'd1);

        // Flush mid-stream
        for (int i = 0; i < 5; i++) begin
            s_axis_tdata = 64'(100 + i); s_axis_tvalid = 1'b1;
            step();
        end
        #1;
        chk("pre_flush_level", 64'(level), 64'd5);
        flush = 1'b1; s_axis_tdata = 64'hBB; rd_en = 1'b1;
        #1;
        chk("flush_tready", 64'(s_axis_tready), 64'd0);
        step();
        flush = 1'b0; s_axis_tvalid = 1'b0; rd_en = 1'b0;
        #1;
        chk("flush_level", 64'(level), 64'd0);
        chk("flush_empty", 64'(empty_n), 64'd0);
        s_axis_tdata = 64'hAA; s_axis_tvalid = 1'b1;
        step();
        s_axis_tvalid = 1'b0;
        #1;
        chk("post_flush_data", rd_data, 64'hAA);

        // Reset clears the sticky flag
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("uf_cleared", 64'(underflow_err), 64'd0);
        chk("reset_level", 64'(level), 64'd0);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
